dac_wr_ctrl: RTL and testbench
==============================

DAC_WR_CTRL -- requirements
Module: dac_wr_ctrl

Interface
REQ-001 Parameter DW, default 8: sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4: input buffer depth; power of two, at least 2.
REQ-003 Parameter SETUP_CYC, default 1: cycles from data/cs valid to wr falling; at least 1.
REQ-004 Parameter PULSE_CYC, default 3: wr low width in cycles; at least 1.
REQ-005 Parameter HOLD_CYC, default 1: cycles from wr rising to the next data change; at least 1.
REQ-006 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous assert, active-high.
REQ-008 Port din, input, DW bits: sample from the upstream waveform generator.
REQ-009 Port din_vld, input, 1 bit: din is valid this cycle.
REQ-010 Port din_rdy, output, 1 bit: block accepts din this cycle.
REQ-011 Port cs, output, 1 bit: DAC chip select, active low.
REQ-012 Port wr, output, 1 bit: DAC write strobe, active low; the DAC latches dout on its rising edge.
REQ-013 Port dout, output, DW bits: DAC data bus.
REQ-014 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 Port fifo_cnt, output, log2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 The FIFO shall push din when din_vld and din_rdy are both high; din_rdy shall equal (fifo_cnt != FIFO_DEPTH).
REQ-017 A push into an empty FIFO shall not be visible for pop until the following cycle (registered non-empty).
REQ-018 Simultaneous push and pop shall leave fifo_cnt unchanged; pointers shall wrap modulo FIFO_DEPTH.
REQ-019 The FSM shall have four states: IDLE, SETUP, PULSE, HOLD.
REQ-020 In IDLE with the FIFO non-empty: pop the head; on the same edge load dout with it, drive cs to 0, and go to SETUP.
REQ-021 SETUP: stay SETUP_CYC cycles, then drive wr to 0 and go to PULSE.
REQ-022 PULSE: stay PULSE_CYC cycles, then drive wr to 1 and go to HOLD.
REQ-023 HOLD: stay HOLD_CYC cycles, then branch on the FIFO. If non-empty, pop, load dout, keep cs at 0, and go to SETUP. If empty, drive cs to 1 and go to IDLE.
REQ-024 dout shall be stable from load until the next load, including the whole time wr is low; in IDLE it shall hold the last written sample.
REQ-025 A back-to-back sample period shall equal SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (5 at defaults).
REQ-026 First-sample latency shall be as follows. The push edge is E. The pop/load edge is E+1. wr falls at E+1+SETUP_CYC. wr rises at E+1+SETUP_CYC+PULSE_CYC.
REQ-027 A single internal phase counter, wide enough for the maximum of the three parameters, shall clear on every state change.
REQ-028 cs, wr, and dout shall be registered outputs, free of glitches.

Reset
REQ-029 While rst is high: cs=1, wr=1, dout=0, busy=0, fifo_cnt=0, din_rdy=0, state IDLE, FIFO pointers and phase counter cleared.
REQ-030 din_rdy shall rise on the first clock edge after rst is released.
REQ-031 Reset asserted mid-transaction shall abort it immediately (asynchronously), discard FIFO contents, and raise wr before or with cs; no partial write resumes after release.

Verification
REQ-032 Push a single sample 0x5A at edge E -> dout=0x5A and cs=0 at E+1; wr=0 over E+2..E+4; wr=1 at E+5; cs=1 at E+6; busy low at E+6.
REQ-033 Burst 0x00,0x40,0x80,0xC0,0xFF with din_vld held high -> din_rdy drops when fifo_cnt=4; exactly 5 wr pulses, 5 cycles apart; cs stays 0 for the whole burst; sampled values in order.
REQ-034 Hold din_vld high with a ramp for 200 cycles -> no sample lost or duplicated; fifo_cnt never exceeds 4; each sample's dout is stable for all 3 wr-low cycles.
REQ-035 Assert rst two cycles into PULSE -> wr=1, cs=1, dout=0, fifo_cnt=0 immediately; after release and with no input, wr and cs stay 1.
REQ-036 Set SETUP_CYC=2, PULSE_CYC=1, HOLD_CYC=3 and send back-to-back samples -> period is 6 cycles; wr low 1 cycle; 3 cycles from wr rising to the next dout change.

Source files
------------

// File: rtl/dac_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
// dac_wr_ctrl_if : upstream sample stream plus parallel DAC write bus
// Rev 1.0
// ============================================================================
interface dac_wr_ctrl_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 3
);
  logic [DW-1:0]    din;
  logic             din_vld;
  logic             din_rdy;
  logic             cs;
  logic             wr;
  logic [DW-1:0]    dout;
  logic             busy;
  logic [CNT_W-1:0] fifo_cnt;

  // master: sample source and DAC-side observer; slave: the write controller
  modport master (
    output din, din_vld,
    input  din_rdy, cs, wr, dout, busy, fifo_cnt
  );

  modport slave (
    input  din, din_vld,
    output din_rdy, cs, wr, dout, busy, fifo_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dac_wr_ctrl.sv
`default_nettype none
// ============================================================================
// dac_wr_ctrl : buffered sample FIFO driving a parallel DAC cs/wr/data bus
// Rev 1.0
// ============================================================================
module dac_wr_ctrl #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic         clk,
  input  logic         rst,
  dac_wr_ctrl_if.slave bus
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int PW      = $clog2(MAX_CYC + 1);

  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYC - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          rdy_en_q;

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic          cs_q;
  logic          wr_q;
  logic          busy_q;
  logic [DW-1:0] dout_q;

  logic          din_rdy;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [DW-1:0] head;

  // cnt_q is registered, so a fresh push into an empty FIFO is poppable one cycle later
  assign not_empty = (cnt_q != '0);
  assign din_rdy   = rdy_en_q && (cnt_q != FULL_CNT);
  assign push      = bus.din_vld && din_rdy;
  assign head      = mem_q[rd_ptr_q];
  assign pop       = not_empty &&
                     ((state_q == S_IDLE) ||
                      ((state_q == S_HOLD) && (phase_q == HOLD_LAST)));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // rdy_en_q keeps din_rdy low during reset and raises it on the first edge after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (not_empty) begin
            dout_q  <= head;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_q == SETUP_LAST) begin
            wr_q    <= 1'b0;
            phase_q <= '0;
            state_q <= S_PULSE;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        S_PULSE: begin
          if (phase_q == PULSE_LAST) begin
            wr_q    <= 1'b1;
            phase_q <= '0;
            state_q <= S_HOLD;
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        S_HOLD: begin
          if (phase_q == HOLD_LAST) begin
            phase_q <= '0;
            if (not_empty) begin
              dout_q  <= head;
              state_q <= S_SETUP;
            end else begin
              cs_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            phase_q <= phase_q + PW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          phase_q <= '0;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_rdy  = din_rdy;
  assign bus.cs       = cs_q;
  assign bus.wr       = wr_q;
  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.fifo_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dac_wr_ctrl : directed self-checking bench for dac_wr_ctrl
// Rev 1.0
// ============================================================================
module tb_dac_wr_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dac_wr_ctrl_if #(.DW(8), .CNT_W(3)) bus1 ();
  dac_wr_ctrl_if #(.DW(8), .CNT_W(3)) bus2 ();

  dac_wr_ctrl #(.DW(8), .FIFO_DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(3), .HOLD_CYC(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  dac_wr_ctrl #(.DW(8), .FIFO_DEPTH(4), .SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // DAC-side observer for dut1: latched samples, pulse timing, data stability
  int         mon_cyc = 0;
  logic       mon_prev_wr = 1'b1;
  logic       mon_prev_cs = 1'b1;
  logic [7:0] mon_prev_dout = '0;
  int         mon_low_len = 0;
  logic [7:0] lat_q[$];
  int         rise_cyc[$];
  int         low_q[$];
  int         cs_falls = 0;
  int         unstable = 0;
  int         max_cnt = 0;

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (rst) begin
      mon_prev_wr = 1'b1;
      mon_prev_cs = 1'b1;
      mon_low_len = 0;
    end else begin
      if (bus1.wr == 1'b0) begin
        mon_low_len++;
        if (bus1.dout !== mon_prev_dout) unstable++;
      end
      if (!mon_prev_wr && bus1.wr) begin
        lat_q.push_back(bus1.dout);
        rise_cyc.push_back(mon_cyc);
        low_q.push_back(mon_low_len);
        mon_low_len = 0;
      end
      if (mon_prev_cs && !bus1.cs) cs_falls++;
      if (int'(bus1.fifo_cnt) > max_cnt) max_cnt = int'(bus1.fifo_cnt);
      mon_prev_wr = bus1.wr;
      mon_prev_cs = bus1.cs;
    end
    mon_prev_dout = bus1.dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    lat_q.delete();
    rise_cyc.delete();
    low_q.delete();
    cs_falls = 0;
    unstable = 0;
    max_cnt  = 0;
  endtask

  task automatic wait_idle1(input int budget);
    int t = 0;
    while ((bus1.busy || bus1.fifo_cnt != 3'd0) && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (bus1.busy !== 1'b0) begin errors++; $display("FAIL idle_timeout busy=%b cnt=%0d after %0d cycles", bus1.busy, bus1.fifo_cnt, t); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.din = '0; bus1.din_vld = 1'b0;
    bus2.din = '0; bus2.din_vld = 1'b0;
    repeat (3) tick();
    checks++; if (bus1.cs !== 1'b1)       begin errors++; $display("FAIL rst_cs got %b exp 1", bus1.cs); end
    checks++; if (bus1.wr !== 1'b1)       begin errors++; $display("FAIL rst_wr got %b exp 1", bus1.wr); end
    checks++; if (bus1.dout !== 8'h00)    begin errors++; $display("FAIL rst_dout got %h exp 00", bus1.dout); end
    checks++; if (bus1.busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", bus1.busy); end
    checks++; if (bus1.fifo_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus1.fifo_cnt); end
    checks++; if (bus1.din_rdy !== 1'b0)  begin errors++; $display("FAIL rst_rdy got %b exp 0", bus1.din_rdy); end
    rst = 1'b0;
    #1;
    checks++; if (bus1.din_rdy !== 1'b0)  begin errors++; $display("FAIL rdy_before_edge got %b exp 0", bus1.din_rdy); end
    tick();
    checks++; if (bus1.din_rdy !== 1'b1)  begin errors++; $display("FAIL rdy_after_edge got %b exp 1", bus1.din_rdy); end
    checks++; if (bus2.din_rdy !== 1'b1)  begin errors++; $display("FAIL rdy2_after_edge got %b exp 1", bus2.din_rdy); end
  endtask

  task automatic test_single();
    int low = 0;
    int bad = 0;
    clear_mon();
    bus1.din = 8'h5A; bus1.din_vld = 1'b1;
    tick();  // push edge E
    bus1.din_vld = 1'b0;
    checks++; if (bus1.fifo_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt_E got %0d exp 1", bus1.fifo_cnt); end
    checks++; if (bus1.cs !== 1'b1)       begin errors++; $display("FAIL single_cs_E got %b exp 1", bus1.cs); end
    tick();  // E+1
    checks++; if (bus1.dout !== 8'h5A)    begin errors++; $display("FAIL single_dout_E1 got %h exp 5a", bus1.dout); end
    checks++; if (bus1.cs !== 1'b0)       begin errors++; $display("FAIL single_cs_E1 got %b exp 0", bus1.cs); end
    checks++; if (bus1.wr !== 1'b1)       begin errors++; $display("FAIL single_wr_E1 got %b exp 1", bus1.wr); end
    checks++; if (bus1.busy !== 1'b1)     begin errors++; $display("FAIL single_busy_E1 got %b exp 1", bus1.busy); end
    for (int i = 0; i < 3; i++) begin  // E+2..E+4
      tick();
      if (bus1.wr == 1'b0) low++;
      if (bus1.dout !== 8'h5A) bad++;
    end
    checks++; if (low != 3)               begin errors++; $display("FAIL single_wr_low got %0d cycles exp 3", low); end
    checks++; if (bad != 0)               begin errors++; $display("FAIL single_dout_hold got %0d bad cycles exp 0", bad); end
    tick();  // E+5
    checks++; if (bus1.wr !== 1'b1)       begin errors++; $display("FAIL single_wr_E5 got %b exp 1", bus1.wr); end
    checks++; if (bus1.cs !== 1'b0)       begin errors++; $display("FAIL single_cs_E5 got %b exp 0", bus1.cs); end
    tick();  // E+6
    checks++; if (bus1.cs !== 1'b1)       begin errors++; $display("FAIL single_cs_E6 got %b exp 1", bus1.cs); end
    checks++; if (bus1.busy !== 1'b0)     begin errors++; $display("FAIL single_busy_E6 got %b exp 0", bus1.busy); end
    checks++; if (bus1.dout !== 8'h5A)    begin errors++; $display("FAIL single_dout_idle got %h exp 5a", bus1.dout); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF};
    int idx = 0;
    int t = 0;
    logic rdy;
    logic [7:0] got;
    clear_mon();
    while (idx < 5 && t < 50) begin
      bus1.din = vals[idx]; bus1.din_vld = 1'b1;
      rdy = bus1.din_rdy;
      tick();
      t++;
      if (rdy) idx++;
    end
    bus1.din_vld = 1'b0;
    checks++; if (idx != 5)               begin errors++; $display("FAIL burst_accepted got %0d exp 5", idx); end
    checks++; if (bus1.fifo_cnt !== 3'd4) begin errors++; $display("FAIL burst_full_cnt got %0d exp 4", bus1.fifo_cnt); end
    checks++; if (bus1.din_rdy !== 1'b0)  begin errors++; $display("FAIL burst_full_rdy got %b exp 0", bus1.din_rdy); end
    wait_idle1(100);
    checks++; if (lat_q.size() != 5)      begin errors++; $display("FAIL burst_pulses got %0d exp 5", lat_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < lat_q.size()) ? lat_q[i] : 8'hxx;
      checks++; if (got !== vals[i])      begin errors++; $display("FAIL burst_sample%0d got %h exp %h", i, got, vals[i]); end
    end
    for (int i = 1; i < 5; i++) begin
      t = (i < rise_cyc.size()) ? rise_cyc[i] - rise_cyc[i-1] : -1;
      checks++; if (t != 5)               begin errors++; $display("FAIL burst_period%0d got %0d exp 5", i, t); end
    end
    checks++; if (cs_falls != 1)          begin errors++; $display("FAIL burst_cs_falls got %0d exp 1", cs_falls); end
  endtask

  task automatic test_ramp();
    logic [7:0] nxt = 8'h10;
    int accepted = 0;
    int bad_val = 0;
    int bad_low = 0;
    logic rdy;
    clear_mon();
    for (int c = 0; c < 200; c++) begin
      bus1.din = nxt; bus1.din_vld = 1'b1;
      rdy = bus1.din_rdy;
      tick();
      if (rdy) begin nxt = nxt + 8'd1; accepted++; end
    end
    bus1.din_vld = 1'b0;
    wait_idle1(200);
    checks++; if (accepted != 44)         begin errors++; $display("FAIL ramp_accepted got %0d exp 44", accepted); end
    checks++; if (lat_q.size() != accepted) begin errors++; $display("FAIL ramp_written got %0d exp %0d", lat_q.size(), accepted); end
    for (int i = 0; i < lat_q.size(); i++) if (lat_q[i] !== 8'(8'h10 + i)) bad_val++;
    checks++; if (bad_val != 0)           begin errors++; $display("FAIL ramp_order got %0d wrong samples exp 0", bad_val); end
    checks++; if (max_cnt != 4)           begin errors++; $display("FAIL ramp_max_cnt got %0d exp 4", max_cnt); end
    checks++; if (unstable != 0)          begin errors++; $display("FAIL ramp_dout_stable got %0d changes exp 0", unstable); end
    foreach (low_q[i]) if (low_q[i] != 3) bad_low++;
    checks++; if (bad_low != 0)           begin errors++; $display("FAIL ramp_wr_width got %0d bad pulses exp 0", bad_low); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] vals [3] = '{8'hA1, 8'hA2, 8'hA3};
    int wr_low = 0;
    int cs_low = 0;
    clear_mon();
    for (int i = 0; i < 3; i++) begin  // pushes at E, E+1, E+2
      bus1.din = vals[i]; bus1.din_vld = 1'b1;
      tick();
    end
    bus1.din_vld = 1'b0;
    tick();  // E+3: second PULSE cycle
    checks++; if (bus1.wr !== 1'b0)       begin errors++; $display("FAIL mid_pre_wr got %b exp 0", bus1.wr); end
    checks++; if (bus1.fifo_cnt !== 3'd2) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 2", bus1.fifo_cnt); end
    rst = 1'b1;
    #1;
    checks++; if (bus1.wr !== 1'b1)       begin errors++; $display("FAIL mid_wr got %b exp 1", bus1.wr); end
    checks++; if (bus1.cs !== 1'b1)       begin errors++; $display("FAIL mid_cs got %b exp 1", bus1.cs); end
    checks++; if (bus1.dout !== 8'h00)    begin errors++; $display("FAIL mid_dout got %h exp 00", bus1.dout); end
    checks++; if (bus1.fifo_cnt !== 3'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", bus1.fifo_cnt); end
    checks++; if (bus1.busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b exp 0", bus1.busy); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!bus1.wr) wr_low++;
      if (!bus1.cs) cs_low++;
    end
    checks++; if (wr_low != 0)            begin errors++; $display("FAIL mid_after_wr got %0d low cycles exp 0", wr_low); end
    checks++; if (cs_low != 0)            begin errors++; $display("FAIL mid_after_cs got %0d low cycles exp 0", cs_low); end
    checks++; if (lat_q.size() != 0)      begin errors++; $display("FAIL mid_no_write got %0d writes exp 0", lat_q.size()); end
  endtask

  task automatic test_timing_params();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    int loads[$];
    int falls[$];
    int rises[$];
    int low = 0;
    logic prev_wr = bus2.wr;
    logic [7:0] prev_dout = bus2.dout;
    int d;
    for (int t = 1; t <= 60; t++) begin
      if (t <= 3) begin bus2.din = vals[t-1]; bus2.din_vld = 1'b1; end
      else bus2.din_vld = 1'b0;
      tick();
      if (bus2.dout !== prev_dout) loads.push_back(t);
      if (prev_wr && !bus2.wr) falls.push_back(t);
      if (!prev_wr && bus2.wr) rises.push_back(t);
      if (!bus2.wr) low++;
      prev_wr = bus2.wr;
      prev_dout = bus2.dout;
    end
    checks++; if (loads.size() != 3)      begin errors++; $display("FAIL t2_loads got %0d exp 3", loads.size()); end
    checks++; if (rises.size() != 3)      begin errors++; $display("FAIL t2_pulses got %0d exp 3", rises.size()); end
    checks++; if (low != 3)               begin errors++; $display("FAIL t2_wr_low got %0d cycles exp 3", low); end
    if (loads.size() == 3 && rises.size() == 3 && falls.size() == 3) begin
      d = loads[1] - loads[0];
      checks++; if (d != 6)               begin errors++; $display("FAIL t2_period1 got %0d exp 6", d); end
      d = loads[2] - loads[1];
      checks++; if (d != 6)               begin errors++; $display("FAIL t2_period2 got %0d exp 6", d); end
      d = falls[0] - loads[0];
      checks++; if (d != 2)               begin errors++; $display("FAIL t2_setup got %0d exp 2", d); end
      d = rises[0] - falls[0];
      checks++; if (d != 1)               begin errors++; $display("FAIL t2_pulse got %0d exp 1", d); end
      d = loads[1] - rises[0];
      checks++; if (d != 3)               begin errors++; $display("FAIL t2_hold got %0d exp 3", d); end
    end else begin
      checks++; errors++;
      $display("FAIL t2_edges got loads=%0d falls=%0d rises=%0d exp 3 each", loads.size(), falls.size(), rises.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ramp();
    test_reset_mid();
    test_timing_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
